// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : cpu_bus_pkg                                                      |
// | Purpose : Shared types and constants for the CPU bus responder: address    |
// |           type encoding from addr_converter, AXI response codes, the       |
// |           responder state enum and the byte-lane select helper.            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package cpu_bus_pkg;

   // Address-type encoding produced by addr_converter. It must stay identical
   // to the encoding on the addr_converter side.
   localparam logic [2:0] ADDR_TYPE_NOT_OP  = 3'd0;
   localparam logic [2:0] ADDR_TYPE_AXI     = 3'd1;
   localparam logic [2:0] ADDR_TYPE_ROM     = 3'd2;
   localparam logic [2:0] ADDR_TYPE_RAM     = 3'd3;
   localparam logic [2:0] ADDR_TYPE_BUTTON  = 3'd4;
   localparam logic [2:0] ADDR_TYPE_LED     = 3'd5;
   localparam logic [2:0] ADDR_TYPE_UNKNOWN = 3'd6;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_AR       = 3'd1,
      ST_R        = 3'd2,
      ST_AW_W     = 3'd3,
      ST_B        = 3'd4,
      ST_INT_WAIT = 3'd5,
      ST_DONE     = 3'd6
   } cpu_bus_state_t;

   // Pick the byte the CPU addressed out of a 32-bit AXI data word.
   function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                            input logic [1:0]  lane);
      return word[8*lane +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_responder_axi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_lite_single_master                                           |
// | Purpose : Issues one AXI4-Lite read or write per start pulse and reports   |
// |           completion, response error or timeout combinationally so the    |
// |           caller can finish in the same cycle the response arrives.        |
// | Ports   : clk, reset_n            clock / async active-low reset           |
// |           start, start_*          transaction request (sampled in IDLE)    |
// |           done, err, timed_out    completion strobes (1 cycle)             |
// |           rdata                   R-channel data, valid with done on read  |
// |           m_axi_*                 AXI4-Lite master channels                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_lite_single_master
   import cpu_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        start_read,
   input  logic [31:0] start_addr,
   input  logic [31:0] start_wdata,
   input  logic [3:0]  start_wstrb,
   output logic        done,
   output logic        err,
   output logic        timed_out,
   output logic [31:0] rdata,
   output logic [31:0] m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [31:0] m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   localparam int             TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  C_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   cpu_bus_state_t r_state;
   logic [TW-1:0]  r_timer;

   logic w_busy;
   logic w_complete;
   logic w_expire;
   logic w_resp_err;
   logic w_aw_done;
   logic w_w_done;

   always_comb begin
      w_busy     = (r_state != ST_IDLE);
      w_complete = ((r_state == ST_R) && m_axi_rvalid) ||
                   ((r_state == ST_B) && m_axi_bvalid);
      // A real response in the last allowed cycle wins over the timeout.
      w_expire   = w_busy && (r_timer == C_TIMER_LAST) && !w_complete;
      w_resp_err = ((r_state == ST_R) && m_axi_rvalid && (m_axi_rresp != AXI_RESP_OKAY)) ||
                   ((r_state == ST_B) && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY));
      // A channel counts as finished once its valid has already dropped or
      // is handshaking right now.
      w_aw_done  = !m_axi_awvalid || m_axi_awready;
      w_w_done   = !m_axi_wvalid  || m_axi_wready;
   end

   assign done      = w_complete || w_expire;
   assign err       = w_resp_err || w_expire;
   assign timed_out = w_expire;
   assign rdata     = m_axi_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_timer       <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         if (w_busy) begin
            r_timer <= r_timer + 1'b1;
         end

         if (w_expire) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
            r_state       <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_timer <= '0;
                     if (start_read) begin
                        m_axi_araddr  <= start_addr;
                        m_axi_arvalid <= 1'b1;
                        r_state       <= ST_AR;
                     end else begin
                        m_axi_awaddr  <= start_addr;
                        m_axi_wdata   <= start_wdata;
                        m_axi_wstrb   <= start_wstrb;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        r_state       <= ST_AW_W;
                     end
                  end
               end
               ST_AR: begin
                  if (m_axi_arready) begin
                     m_axi_arvalid <= 1'b0;
                     m_axi_rready  <= 1'b1;
                     r_state       <= ST_R;
                  end
               end
               ST_R: begin
                  if (m_axi_rvalid) begin
                     m_axi_rready <= 1'b0;
                     r_state      <= ST_IDLE;
                  end
               end
               ST_AW_W: begin
                  if (w_aw_done && w_w_done) begin
                     m_axi_awvalid <= 1'b0;
                     m_axi_wvalid  <= 1'b0;
                     m_axi_bready  <= 1'b1;
                     r_state       <= ST_B;
                  end else begin
                     if (m_axi_awready) m_axi_awvalid <= 1'b0;
                     if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                  end
               end
               ST_B: begin
                  if (m_axi_bvalid) begin
                     m_axi_bready <= 1'b0;
                     r_state      <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_bus_responder                                                |
// | Purpose : Completes decoded CPU bus cycles. Dispatches each cycle to the   |
// |           AXI4-Lite master, the internal ROM/RAM port or the button/LED    |
// |           registers, holds cpu_ready low until the target answers and      |
// |           returns the read byte on cpu_rdata.                              |
// | Ports   : clk, reset_n              clock / async active-low reset         |
// |           req_valid, is_read,       decoded CPU cycle from addr_converter  |
// |           addr_type, A32, D32, wstrb                                       |
// |           cpu_ready, cpu_rdata      wait-state control and read byte       |
// |           m_axi_*                   AXI4-Lite master                       |
// |           int_*                     internal BRAM port                     |
// |           button, led, err_sticky   local registers / sticky error flag    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module cpu_bus_responder
   import cpu_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int LED_WIDTH      = 8,
   parameter int BTN_WIDTH      = 4
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   input  logic                 is_read,
   input  logic [2:0]           addr_type,
   input  logic [31:0]          A32,
   input  logic [31:0]          D32,
   input  logic [3:0]           wstrb,
   output logic                 cpu_ready,
   output logic [7:0]           cpu_rdata,
   output logic [31:0]          m_axi_awaddr,
   output logic                 m_axi_awvalid,
   input  logic                 m_axi_awready,
   output logic [31:0]          m_axi_wdata,
   output logic [3:0]           m_axi_wstrb,
   output logic                 m_axi_wvalid,
   input  logic                 m_axi_wready,
   input  logic [1:0]           m_axi_bresp,
   input  logic                 m_axi_bvalid,
   output logic                 m_axi_bready,
   output logic [31:0]          m_axi_araddr,
   output logic                 m_axi_arvalid,
   input  logic                 m_axi_arready,
   input  logic [31:0]          m_axi_rdata,
   input  logic [1:0]           m_axi_rresp,
   input  logic                 m_axi_rvalid,
   output logic                 m_axi_rready,
   output logic                 int_en,
   output logic                 int_we,
   output logic [15:0]          int_addr,
   output logic [7:0]           int_wdata,
   output logic                 int_rom_sel,
   input  logic [7:0]           int_rdata,
   input  logic [BTN_WIDTH-1:0] button,
   output logic [LED_WIDTH-1:0] led,
   output logic                 err_sticky
);

   // Dispatch state. For AXI cycles this FSM sits in ST_AR (read) or ST_AW_W
   // (write) until the master reports done; the finer AR/R/AW_W/B phase
   // sequencing lives inside the AXI master.
   cpu_bus_state_t r_state;
   logic           r_is_read;
   logic [1:0]     r_lane;

   logic        w_axi_start;
   logic        w_axi_done;
   logic        w_axi_err;
   logic        w_axi_timeout;
   logic [31:0] w_axi_rdata;

   // The AXI master must see the request on the accepting edge so that
   // arvalid/awvalid rise together with the dispatch state change.
   assign w_axi_start = (r_state == ST_IDLE) && req_valid && (addr_type == ADDR_TYPE_AXI);

   axi_lite_single_master #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_axi (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (w_axi_start),
      .start_read    (is_read),
      .start_addr    (A32),
      .start_wdata   (D32),
      .start_wstrb   (wstrb),
      .done          (w_axi_done),
      .err           (w_axi_err),
      .timed_out     (w_axi_timeout),
      .rdata         (w_axi_rdata),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_is_read   <= 1'b0;
         r_lane      <= 2'd0;
         cpu_ready   <= 1'b0;
         cpu_rdata   <= 8'h00;
         int_en      <= 1'b0;
         int_we      <= 1'b0;
         int_addr    <= 16'h0000;
         int_wdata   <= 8'h00;
         int_rom_sel <= 1'b0;
         led         <= '0;
         err_sticky  <= 1'b0;
      end else begin
         // BRAM strobes are single-cycle pulses.
         int_en <= 1'b0;
         int_we <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (req_valid && (addr_type != ADDR_TYPE_NOT_OP)) begin
                  r_is_read <= is_read;
                  r_lane    <= A32[1:0];
                  int_addr  <= A32[15:0];
                  int_wdata <= D32[7:0];
                  case (addr_type)
                     ADDR_TYPE_AXI: begin
                        r_state <= is_read ? ST_AR : ST_AW_W;
                     end
                     ADDR_TYPE_ROM, ADDR_TYPE_RAM: begin
                        int_en      <= 1'b1;
                        int_we      <= !is_read && (addr_type == ADDR_TYPE_RAM);
                        int_rom_sel <= (addr_type == ADDR_TYPE_ROM);
                        r_state     <= ST_INT_WAIT;
                     end
                     ADDR_TYPE_BUTTON: begin
                        if (is_read) cpu_rdata <= 8'(button);
                        cpu_ready <= 1'b1;
                        r_state   <= ST_DONE;
                     end
                     ADDR_TYPE_LED: begin
                        if (is_read) cpu_rdata <= 8'(led);
                        else         led       <= D32[LED_WIDTH-1:0];
                        cpu_ready <= 1'b1;
                        r_state   <= ST_DONE;
                     end
                     default: begin
                        // Unmapped space: reads float high, writes vanish.
                        if (is_read) cpu_rdata <= 8'hFF;
                        cpu_ready <= 1'b1;
                        r_state   <= ST_DONE;
                     end
                  endcase
               end
            end
            ST_AR, ST_R, ST_AW_W, ST_B: begin
               if (w_axi_done) begin
                  if (r_is_read || w_axi_timeout) begin
                     cpu_rdata <= w_axi_err ? 8'hFF : lane_byte(w_axi_rdata, r_lane);
                  end
                  if (w_axi_err) err_sticky <= 1'b1;
                  cpu_ready <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_INT_WAIT: begin
               // int_rdata is sampled at the edge that closes the int_en pulse.
               if (r_is_read) cpu_rdata <= int_rdata;
               cpu_ready <= 1'b1;
               r_state   <= ST_DONE;
            end
            ST_DONE: begin
               // If the CPU already released the cycle this is a 1-cycle pulse.
               if (!req_valid) begin
                  cpu_ready <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               cpu_ready <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
